// File: rtl/div_radix2.sv
// ---------------------------------------------------------------------------
// div_radix2 -- iterative radix-2 restoring divider for the EX-stage divide
// request interface. One quotient bit per cycle, MSB first.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous reset, active-high
//   div              in   divide request (level, held while the op sits in EX)
//   div_signed       in   1: signed div/mod, 0: unsigned divu/modu
//   x                in   dividend (sampled at accept)
//   y                in   divisor  (sampled at accept)
//   div_total_result out  {quotient, remainder}, registered, held until next
//   es_go            out  accept acknowledge (combinational, IDLE only)
//   complete         out  one-cycle result-valid pulse (registered)
//
// Latency: accept in cycle T, complete in T+33, next accept no earlier than T+34.
// ---------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div,
    input  logic                 div_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   div_total_result,
    output logic                 es_go,
    output logic                 complete
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand and iteration registers
    logic [WIDTH-1:0]   r_ax;       // |x|, shifted left each iteration
    logic [WIDTH-1:0]   r_ay;       // |y|
    logic [WIDTH-1:0]   r_x;        // original dividend for divide-by-zero
    logic               r_qneg;
    logic               r_rneg;
    logic               r_yzero;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [5:0]         r_cnt;
    logic               r_complete;
    logic [2*WIDTH-1:0] r_result;

    // Combinational helpers
    logic               w_last;
    logic [WIDTH-1:0]   w_ax_in;
    logic [WIDTH-1:0]   w_ay_in;
    logic [WIDTH:0]     w_t;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_result;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and accept acknowledge
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        es_go       = 1'b0;
        case (r_state)
            IDLE: begin
                if (div) begin
                    es_go       = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_last = (r_state == CALC) && (r_cnt == LAST);

    // Operand magnitudes at accept
    assign w_ax_in = (div_signed && x[WIDTH-1]) ? -x : x;
    assign w_ay_in = (div_signed && y[WIDTH-1]) ? -y : y;

    // One restoring step. The dividend is consumed MSB first by shifting
    // r_ax left, so r_ax[WIDTH-1] is ax[31-i] of iteration i; the quotient is
    // likewise shifted in from the LSB, landing bit i at q[31-i] after 32 steps.
    assign w_t       = {r_rem, r_ax[WIDTH-1]} - {1'b0, r_ay};
    assign w_rem_nxt = w_t[WIDTH] ? {r_rem[WIDTH-2:0], r_ax[WIDTH-1]} : w_t[WIDTH-1:0];
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

    // Final result, built from the last iteration so it is registered on the
    // CALC->DONE edge and visible for the whole DONE cycle.
    always_comb begin
        w_result = '0;
        if (r_yzero) begin
            w_result = {{WIDTH{1'b1}}, r_x};
        end else begin
            w_result[2*WIDTH-1:WIDTH] = r_qneg ? -w_q_nxt : w_q_nxt;
            w_result[WIDTH-1:0]       = r_rneg ? -w_rem_nxt : w_rem_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ax       <= '0;
            r_ay       <= '0;
            r_x        <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_yzero    <= 1'b0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_complete <= 1'b0;
            r_result   <= '0;
        end else begin
            r_complete <= w_last;
            if (es_go) begin
                r_ax    <= w_ax_in;
                r_ay    <= w_ay_in;
                r_x     <= x;
                r_qneg  <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                r_rneg  <= div_signed & x[WIDTH-1];
                r_yzero <= (y == '0);
                r_rem   <= '0;
                r_q     <= '0;
                r_cnt   <= '0;
            end else if (r_state == CALC) begin
                r_ax  <= {r_ax[WIDTH-2:0], 1'b0};
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
                if (w_last) begin
                    r_result <= w_result;
                end
            end
        end
    end

    assign complete         = r_complete;
    assign div_total_result = r_result;

endmodule

// File: tb/tb_div_radix2.sv
// ---------------------------------------------------------------------------
// tb_div_radix2 -- directed self-checking bench for div_radix2.
// ---------------------------------------------------------------------------
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        div;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] div_total_result;
    logic        es_go;
    logic        complete;

    int total = 0;
    int bad   = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .div              (div),
        .div_signed       (div_signed),
        .x                (x),
        .y                (y),
        .div_total_result (div_total_result),
        .es_go            (es_go),
        .complete         (complete)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide, then check acceptance, 33-cycle latency, the result,
    // and that complete is a single-cycle pulse with the result held after.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        @(posedge clk); #1;
        div = 1'b1; div_signed = sgn; x = a; y = b;
        #1;
        check({tag, "_es_go"}, 64'(es_go), 64'd1);
        @(posedge clk); #1;
        // Scramble inputs: the result must come from the accepted operands.
        div = 1'b0; div_signed = ~sgn; x = 32'h5A5A5A5A; y = 32'h00000003;
        n = 1;
        while (complete !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_result"}, div_total_result, exp);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(complete), 64'd0);
        check({tag, "_hold"}, div_total_result, exp);
    endtask

    initial begin
        int n;
        int go_hi;
        int seen;

        rst = 1'b1; div = 1'b0; div_signed = 1'b0; x = '0; y = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_complete", 64'(complete), 64'd0);
        check("rst_result", div_total_result, 64'h0);
        check("rst_es_go_lo", 64'(es_go), 64'd0);
        div = 1'b1; #1;
        check("rst_es_go_hi", 64'(es_go), 64'd1);
        @(posedge clk); #1;
        div = 1'b0; rst = 1'b0;

        // Main function
        do_div("u7_2",       1'b0, 32'd7,        32'd2,        64'h00000003_00000001);
        do_div("s-7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFD_FFFFFFFF);
        do_div("s7_-2",      1'b1, 32'd7,        32'hFFFFFFFE, 64'hFFFFFFFD_00000001);
        do_div("s-7_-2",     1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'h00000003_FFFFFFFF);
        do_div("uF9_2",      1'b0, 32'hFFFFFFF9, 32'd2,        64'h7FFFFFFC_00000001);
        do_div("s_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
        do_div("u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_00000000);
        do_div("u_div0",     1'b0, 32'h00001234, 32'd0,        64'hFFFFFFFF_00001234);
        do_div("s_div0",     1'b1, 32'h00001234, 32'd0,        64'hFFFFFFFF_00001234);
        do_div("s_div0_neg", 1'b1, 32'h80000000, 32'd0,        64'hFFFFFFFF_80000000);

        // Back-to-back: div held high, operands change at T+5.
        @(posedge clk); #1;
        div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
        #1;
        check("b2b_es_go_T", 64'(es_go), 64'd1);
        go_hi = 0;
        n = 0;
        while (complete !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                x = 32'd50; y = 32'd3;
                #1;
            end
            if (es_go === 1'b1) go_hi++;
        end
        check("b2b_latency", 64'(n), 64'd33);
        check("b2b_es_go_busy", 64'(go_hi), 64'd0);
        check("b2b_result1", div_total_result, 64'h0000000E_00000002);
        @(posedge clk); #1;
        check("b2b_es_go_T34", 64'(es_go), 64'd1);
        check("b2b_pulse", 64'(complete), 64'd0);
        @(posedge clk); #1;
        div = 1'b0;
        n = 1;
        while (complete !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency2", 64'(n), 64'd33);
        check("b2b_result2", div_total_result, 64'h00000010_00000002);

        // Reset mid-operation, with div asserted during reset.
        @(posedge clk); #1;
        div = 1'b1; div_signed = 1'b0; x = 32'd9; y = 32'd4;
        #1;
        check("rmid_es_go_T", 64'(es_go), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            div = 1'b0;
        end
        // Now in T+10: reset sampled at the end of this cycle.
        rst = 1'b1; div = 1'b1;
        @(posedge clk); #1;
        check("rmid_complete", 64'(complete), 64'd0);
        check("rmid_result", div_total_result, 64'h0);
        check("rmid_idle", 64'(es_go), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; div = 1'b1;
        #1;
        // Still IDLE: rst beat div on the previous edge, so nothing was accepted.
        check("rmid_no_accept", 64'(es_go), 64'd1);
        div = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (complete === 1'b1) seen++;
        end
        check("rmid_no_complete", 64'(seen), 64'd0);
        check("rmid_result_held", div_total_result, 64'h0);

        // Normal operation after the aborted divide.
        do_div("post_rst", 1'b0, 32'd9, 32'd4, 64'h00000002_00000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative 32-bit radix-2 restoring divider that serves as the responder for the execute-stage divide request interface. It accepts `div`/`div_signed`/`x`/`y` from the ALU, acknowledges acceptance with `es_go`, computes one quotient bit per cycle, and returns `{quotient, remainder}` with a one-cycle `complete` pulse. The later pipeline stage selects the quotient half (div/divu) or the remainder half (mod/modu).

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `div` in 1: request, level. Asserted while a div/divu/mod/modu instruction sits valid in EX.
- `div_signed` in 1: 1 selects signed (div/mod), 0 selects unsigned (divu/modu). Sampled at accept.
- `x` in 32: dividend. Sampled at accept.
- `y` in 32: divisor. Sampled at accept.
- `div_total_result` out 64: `{quotient[31:0], remainder[31:0]}`. Registered.
- `es_go` out 1: accept acknowledge. Combinational: `div & (state==IDLE)`.
- `complete` out 1: result-valid pulse. Registered, one cycle.

## Operation
- States are IDLE, CALC and DONE.
- IDLE:
  - When `div=1`, assert `es_go`, latch `div_signed`, `x` and `y`, and go to CALC.
  - Otherwise stay in IDLE.
- Operand prep at accept:
  - `ax = (div_signed & x[31]) ? -x : x`
  - `ay = (div_signed & y[31]) ? -y : y`
  - `qneg = div_signed & (x[31]^y[31])`
  - `rneg = div_signed & x[31]`
  - `yzero = (y==0)`
- CALC runs 32 iterations with a 6-bit counter from 0 to 31, one iteration per cycle, MSB first. Each iteration:
  - Compute `t = {rem[31:0], ax[31-i]} - {1'b0, ay}` using a 33-bit partial remainder.
  - If `t[32]==0`, set `rem = t[31:0]` and `q[31-i] = 1`.
  - Otherwise `rem` shifts in the dividend bit and `q[31-i] = 0`.
  - After iteration 31, go to DONE.
- DONE lasts one cycle. It writes `div_total_result`, asserts `complete=1`, then returns to IDLE unconditionally.
  - Normal case: quotient is `qneg ? -q : q`, remainder is `rneg ? -rem : rem`.
  - Divide by zero (`yzero`): quotient is `32'hFFFFFFFF` and remainder is the original `x`, in both modes. No sign fixup is applied.
  - Signed overflow: `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000` and remainder `0` through the normal path.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- `div_total_result` holds its value until the next DONE overwrites it.
- While in CALC or DONE:
  - `div`, `x`, `y` and `div_signed` are ignored.
  - Dropping `div` does not abort the operation.
- There is no flush input; only `rst` cancels an operation.

## Timing
- Reset values:
  - state is IDLE
  - `complete = 0`
  - `div_total_result = 64'h0`
  - counter is 0
  - `es_go` evaluates to `div`
- Accept happens in cycle T, with `es_go=1` in the same cycle.
- CALC occupies T+1 through T+32.
- DONE is T+33: `complete=1`, and `div_total_result` is valid from T+33 onward.
- Latency is 33 cycles from accept to `complete`.
- The earliest next accept is T+34, so throughput is one divide per 34 cycles.
- `rst` in any state:
  - Next cycle is IDLE with `complete=0` and `div_total_result=0`.
  - An in-flight result is discarded and no `complete` is issued for it.
- If `rst` and `div` are both high in the same cycle, `rst` wins: there is no accept and `es_go` is ignored by state.
- `es_go` is never high outside IDLE. `complete` is never high on two consecutive cycles.

## Test plan
- Unsigned 7/2:
  - `div=1`, `div_signed=0`, `x=7`, `y=2` → `es_go=1` at T.
  - `complete=1` at exactly T+33, with `div_total_result=64'h00000003_00000001`.
- Signed -7/2:
  - `x=32'hFFFFFFF9`, `y=2` → `64'hFFFFFFFD_FFFFFFFF`.
  - Also 7/-2 → `64'hFFFFFFFD_00000001`.
- Extremes:
  - Signed `0x80000000 / 0xFFFFFFFF` → `64'h80000000_00000000`.
  - Unsigned `0xFFFFFFFF / 1` → `64'hFFFFFFFF_00000000`.
- Divide by zero with `x=32'h1234`, `y=0`, both modes → `64'hFFFFFFFF_00001234`.
- Back-to-back:
  - Hold `div=1` continuously and change operands at T+5 → the first result uses the T operands.
  - Second `es_go` appears at T+34; `es_go=0` throughout T+1..T+33.
- Reset mid-op: assert `rst` at T+10 → IDLE at T+11, `div_total_result=0`, and no `complete` at T+33.
